// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply or restoring divide over W cycles,
// then a single register-file write cycle.
module muldiv_unit #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] opA,
  input  logic [W-1:0] opB,
  input  logic [2:0]   destIn,
  output logic         busy,
  output logic         done,
  output logic         regWrite,
  output logic [2:0]   Rd,
  output logic [W-1:0] writeValue,
  output logic [1:0]   state_dbg
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [1:0]     op_r;
  logic [W-1:0]   a_r, b_r, lo_r;
  logic [W:0]     hi_r;
  logic           last_iter;

  logic           is_div;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic           div_ge;
  logic [W:0]     hi_nxt;
  logic [W-1:0]   lo_nxt, result;

  assign last_iter = (cnt == CW'(W - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == WB);
  assign regWrite  = (state == WB);
  assign state_dbg = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // hi_r is the product high half (multiply) or the partial remainder (divide);
  // lo_r shifts out multiplier bits, or shifts out dividend bits while shifting in quotient bits.
  always_comb begin
    is_div    = op_r[1];
    mul_sum   = {1'b0, hi_r[W-1:0]} + (lo_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
    div_shift = {hi_r[W-1:0], lo_r[W-1]};
    div_diff  = div_shift - {1'b0, b_r};
    div_ge    = (div_shift >= {1'b0, b_r});
    if (is_div) begin
      hi_nxt = div_ge ? div_diff : div_shift;
      lo_nxt = {lo_r[W-2:0], div_ge};
    end else begin
      hi_nxt = {1'b0, mul_sum[W:1]};
      lo_nxt = {mul_sum[0], lo_r[W-1:1]};
    end
    case (op_r)
      2'd0:    result = lo_nxt;
      2'd1:    result = hi_nxt[W-1:0];
      2'd2:    result = lo_nxt;
      default: result = hi_nxt[W-1:0];
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt        <= '0;
      op_r       <= '0;
      a_r        <= '0;
      b_r        <= '0;
      lo_r       <= '0;
      hi_r       <= '0;
      Rd         <= '0;
      writeValue <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= opA;
            b_r  <= opB;
            op_r <= op;
            Rd   <= destIn;
            hi_r <= '0;
            lo_r <= op[1] ? opA : opB;
            cnt  <= '0;
          end
        end
        RUN: begin
          hi_r <= hi_nxt;
          lo_r <= lo_nxt;
          cnt  <= last_iter ? '0 : cnt + CW'(1);
          if (last_iter) writeValue <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases, held-start back-to-back, mid-run reset, random ops
// against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] opA, opB;
  logic [2:0]   destIn;
  logic         busy, done, regWrite;
  logic [2:0]   Rd;
  logic [W-1:0] writeValue;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .op(op), .opA(opA), .opB(opB),
    .destIn(destIn), .busy(busy), .done(done), .regWrite(regWrite), .Rd(Rd),
    .writeValue(writeValue), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] ref_model(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    case (f)
      2'd0:    return W'(p % 256);
      2'd1:    return W'(p / 256);
      2'd2:    return (b == 0) ? {W{1'b1}} : W'(int'(a) / int'(b));
      default: return (b == 0) ? a : W'(int'(a) % int'(b));
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called right after the accepting edge E0; samples each negedge through the cycle after WB.
  task automatic watch(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] d, input bit keep,
                       input logic [1:0] nf, input logic [W-1:0] na, input logic [W-1:0] nb,
                       input logic [2:0] nd);
    logic [W-1:0] exp;
    exp = ref_model(f, a, b);
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge CLK);
      check($sformatf("ctl k=%0d op=%0d", k, f), {13'd0, busy, done, regWrite},
            {13'd0, (k <= W), (k == W), (k == W)});
      if (k >= W) begin
        check($sformatf("value op=%0d a=%0h b=%0h k=%0d", f, a, b, k), {8'd0, writeValue}, {8'd0, exp});
        check($sformatf("rd k=%0d", k), {13'd0, Rd}, {13'd0, d});
      end
      if (keep && k == W + 1) begin
        op = nf; opA = na; opB = nb; destIn = nd;
      end else begin
        if (!keep) start = 1'b0;
        op = 2'($urandom_range(0, 3)); opA = W'($urandom); opB = W'($urandom);
        destIn = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic issue(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] d);
    @(negedge CLK);
    start = 1'b1; op = f; opA = a; opB = b; destIn = d;
    @(posedge CLK);
    watch(f, a, b, d, 1'b0, 2'd0, '0, '0, 3'd0);
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; op = '0; opA = '0; opB = '0; destIn = '0;
    #12;
    check("reset outputs", {busy, done, regWrite, Rd, writeValue}, 16'd0);
    @(negedge CLK) RST_N = 1'b1;

    issue(2'd0, 8'h0D, 8'h0B, 3'd3);
    issue(2'd1, 8'h0D, 8'h0B, 3'd3);
    issue(2'd0, 8'hFF, 8'hFF, 3'd1);
    issue(2'd1, 8'hFF, 8'hFF, 3'd2);
    issue(2'd0, 8'h00, 8'hA5, 3'd4);
    issue(2'd1, 8'h00, 8'hA5, 3'd5);
    issue(2'd2, 8'hC8, 8'h07, 3'd6);
    issue(2'd3, 8'hC8, 8'h07, 3'd7);
    issue(2'd2, 8'h07, 8'hC8, 3'd0);
    issue(2'd3, 8'h07, 8'hC8, 3'd1);
    issue(2'd2, 8'hFF, 8'h01, 3'd2);
    issue(2'd3, 8'hFF, 8'h01, 3'd3);
    issue(2'd2, 8'h5A, 8'h00, 3'd4);
    issue(2'd3, 8'h5A, 8'h00, 3'd5);

    // start held high: second op must be accepted exactly at E(W+2) with the values present then
    @(negedge CLK);
    start = 1'b1; op = 2'd2; opA = 8'hC8; opB = 8'h07; destIn = 3'd6;
    @(posedge CLK);
    watch(2'd2, 8'hC8, 8'h07, 3'd6, 1'b1, 2'd3, 8'h65, 8'h0A, 3'd1);
    watch(2'd3, 8'h65, 8'h0A, 3'd1, 1'b0, 2'd0, '0, '0, 3'd0);

    // reset mid-run at cnt=4: everything clears at once and no write follows
    @(negedge CLK);
    start = 1'b1; op = 2'd0; opA = 8'h33; opB = 8'h44; destIn = 3'd5;
    @(posedge CLK);
    @(negedge CLK) start = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 check("async reset clear", {busy, done, regWrite, Rd, writeValue}, 16'd0);
    @(negedge CLK) RST_N = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      check($sformatf("post-reset idle k=%0d", k), {14'd0, busy, regWrite}, 16'd0);
    end
    issue(2'd0, 8'h33, 8'h44, 3'd5);

    for (int i = 0; i < 30; i++)
      issue(2'($urandom_range(0, 3)), W'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom),
            3'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 8-bit multiply/divide unit for the CSE141L core, sitting between the register file's read ports and its write port. It captures the two operand values read from the register file (val1, val2) and the destination register index, runs a shift-add multiply or restoring divide over W cycles, then issues exactly one register-file write (regWrite, Rd, writeValue). While busy is high, the core stalls fetch/decode and must not drive the register-file write port.

## Interface
- W, default 8: operand/result width; iteration count equals W.
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  2  0=MULLO (low W bits of product), 1=MULHI (high W bits), 2=DIVU (unsigned quotient), 3=REMU (unsigned remainder).
- opA  input  W  multiplicand / dividend (from RF val1).
- opB  input  W  multiplier / divisor (from RF val2).
- destIn  input  3  destination register index.
- busy  output  1  high in RUN and WB; combinational from state.
- done  output  1  one-cycle pulse, high in WB.
- regWrite  output  1  RF write enable, high only in WB.
- Rd  output  3  latched destination index.
- writeValue  output  W  result; registered and held until next WB or reset.

## Operation
- States: IDLE, RUN, WB. Iteration counter cnt, width clog2(W).
- IDLE: on edge with start=1, latch opA, opB, op, destIn; cnt<=0; go to RUN. start=0 stays IDLE.
- RUN: one iteration per edge, cnt<=cnt+1; the edge performing iteration cnt==W-1 goes to WB and loads writeValue.
- WB: regWrite=1, done=1 for this cycle only; next edge -> IDLE unconditionally.
- start while in RUN or WB is ignored (no queueing; inputs not re-latched).
- Multiply: unsigned shift-add into 2W-bit product; MULLO = product[W-1:0], MULHI = product[2W-1:W]. No overflow flag.
- Divide: unsigned restoring, one quotient bit per iteration, MSB first; W+1-bit partial remainder so subtraction never wraps.
- Divide by zero (opB latched as 0): quotient = all ones (0xFF for W=8), remainder = latched opA. Still takes the full W cycles; no exception.
- Operands are consumed only from latched copies; opA/opB/destIn may change freely after the start edge.
- Reset (any state, any cnt): state<=IDLE, cnt<=0, busy=0, done=0, regWrite=0, Rd=0, writeValue=0. Aborted operation produces no write.

## Timing
- Edge E0 accepts start. RUN occupies the cycles after E0..E(W-1) edges; edge EW enters WB.
- regWrite/done high during the cycle between EW and E(W+1); RF commits writeValue on E(W+1). For W=8: start-to-commit = 9 edges.
- busy high from the cycle after E0 through the WB cycle inclusive; low the cycle after E(W+1).
- A new start is first accepted on edge E(W+2) (cycle after WB returns to IDLE); back-to-back throughput one op per W+2 cycles.
- writeValue, Rd stable throughout WB; regWrite is never high outside WB.
- Asynchronous reset deasserts all outputs immediately, independent of CLK.

## Test plan
- MULLO/MULHI 0x0D*0x0B, destIn=3 -> WB after 8 RUN cycles: MULLO writeValue=0x8F, MULHI=0x00, Rd=3, regWrite exactly 1 cycle.
- MULLO/MULHI 0xFF*0xFF -> 0x01 and 0xFE respectively; 0x00*0xA5 -> 0x00/0x00.
- DIVU/REMU 200/7 (0xC8/0x07) -> quotient 0x1C, remainder 0x04; 0x07/0xC8 -> 0x00, 0x07; 0xFF/0x01 -> 0xFF, 0x00.
- Divide by zero 0x5A/0x00 -> DIVU 0xFF, REMU 0x5A, same 9-edge latency, busy timing unchanged.
- start held high continuously with changing opA/opB/destIn during RUN -> first op's result written once, then next start accepted exactly at E10; no extra regWrite.
- RST_N pulsed low mid-RUN (cnt=4) -> busy, done, regWrite, writeValue, Rd go 0 immediately; no write follows; a fresh start after release completes normally with correct result.
